alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Front-end sequencer for the team's 8-bit combinational ALU (4-bit op, operands n1/n2, result s1).
- Accepts one instruction word per valid/ready handshake and reads operands from a 4-entry internal register file.
- Drives the ALU, captures its result, writes the result back, and returns it on a valid/ready response channel.
- Sits between the instruction source (test sequencer or UART loader) and the ALU instance.

Parameters:
- DATA_W, 8, operand/result width; fixed at 8 to match the ALU.
- REG_CNT, 4, register file depth; register indexes are 2 bits.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  controller can accept an instruction.
- in_instr  in  20  instruction fields:
  - [19:16] op
  - [15:14] rd
  - [13:12] rs1
  - [11:10] rs2
  - [9] imm_sel
  - [8] reserved, ignored
  - [7:0] imm
- alu_n1  out  8  ALU operand 1.
- alu_n2  out  8  ALU operand 2.
- alu_op  out  4  ALU op code.
- alu_s1  in  8  ALU result, combinational from alu_n1/alu_n2/alu_op.
- out_valid  out  1  response valid.
- out_ready  in  1  response accepted by consumer.
- out_data  out  8  result value.
- out_rd  out  2  destination register of the response.
- out_err  out  1  illegal op flag.
- ops_done  out  CNT_W  count of completed responses.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - state=IDLE
  - all register-file entries = 0
  - alu_n1, alu_n2 = 0; alu_op = 4'b0000
  - out_valid=0, out_data=0, out_rd=0, out_err=0, ops_done=0
  - in_ready=0 while in reset; in_ready=1 from the first clock after release.
- Legal op codes:
  - 0000 add; 1000 sub
  - 0001 shl; 0101 shr logical; 1101 shr arithmetic
  - 0010 slt unsigned; 0011 slt signed
  - 0100 xnor; 0110 and; 0111 or
- Illegal op codes: 1001, 1010, 1011, 1100, 1110, 1111.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, register alu_op=op and alu_n1=RF[rs1].
  - Register alu_n2 = imm when imm_sel=1, else RF[rs2].
  - Latch rd, then go to EXEC, or straight to RESP if op is illegal.
- EXEC (exactly one cycle):
  - in_ready=0.
  - At the clock edge, capture out_data=alu_s1 and out_rd=rd, set out_err=0.
  - Write RF[rd]=alu_s1 on the same edge; set out_valid=1; go to RESP.
- Illegal op path:
  - No ALU execution and no register-file write.
  - Enter RESP with out_data=0, out_err=1; alu_op is held at the previous value.
- RESP:
  - out_valid held high with out_data, out_rd and out_err stable until out_ready=1.
  - On handshake: out_valid=0, ops_done increments, go to IDLE.
- Latency:
  - Legal op accepted at edge k gives out_valid=1 after edge k+1.
  - Illegal op accepted at edge k gives out_valid=1 after edge k.
  - Maximum throughput is one instruction per 3 cycles with out_ready held at 1.
- in_ready is 0 in EXEC and RESP; in_instr is ignored there even if in_valid=1.
- Operand hazard: rs1 or rs2 equal to the previous rd reads the already-written value, since writeback completes before IDLE.
- Shifts pass the full 8-bit n2 as the shift amount; amounts of 8 or more produce the ALU's natural result (0, or sign fill for 1101). The controller does not clamp.
- ops_done wraps from 2^CNT_W-1 to 0; it counts illegal responses too.
- Reset mid-operation (EXEC or RESP) aborts the instruction, with all state returning to reset values.

Decomposition:
- alu_pkg holds:
  - op code localparams: OP_ADD, OP_SUB, OP_SLL, OP_SLTU, OP_SLT, OP_XNOR, OP_SRL, OP_SRA, OP_AND, OP_OR
  - the function op_is_legal()
  - the state enum state_t
  - instruction field bit positions
- One sub-module, alu_regfile:
  - REG_CNT x DATA_W entries, 2 async read ports, 1 synchronous write port.
  - Asynchronous active-low reset of all entries to 0.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
1. Reset, then add immediate to r1 (op=0000, rd=1, rs1=0, imm_sel=1, imm=8'h05) -> out_valid after 1 cycle with out_data=8'h05, out_rd=1, out_err=0; RF[1]=5; ops_done=1.
2. Back-to-back dependence, with r1=5: sub r2=r1-r1, then slt signed r3=(r1 < 0xFB via imm) -> out_data 8'h00, then 8'h00 (5 < -5 is false); repeat with op=0010 -> 8'h01 (5 < 251 unsigned).
3. Arithmetic shift, with r1=8'h80: op=1101, imm=2 -> out_data=8'hE0; op=0101, imm=2 -> 8'h20; op=0001, imm=9 -> 8'h00.
4. Illegal op 4'b1110 with rd=1 -> out_err=1, out_data=0, RF[1] unchanged; in_ready=1 in the cycle after the response handshake.
5. Backpressure: hold out_ready=0 for 5 cycles in RESP -> out_valid and out_data stable, in_ready=0, a new in_valid is ignored; on out_ready=1, exactly one completion is counted.
6. Assert rst_n=0 during EXEC -> all outputs and RF entries read 0 immediately, with no response emitted; ops_done wraps 255->0 after 256 responses.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, instruction
// field positions, controller states and the op legality check.
package alu_pkg;

    // ALU op codes understood by the downstream combinational ALU
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_XNOR = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;

    // Instruction word layout
    localparam int INSTR_W  = 20;
    localparam int OP_LSB   = 16;
    localparam int OP_W     = 4;
    localparam int RD_LSB   = 14;
    localparam int RS1_LSB  = 12;
    localparam int RS2_LSB  = 10;
    localparam int IMM_SEL  = 9;
    localparam int RSVD_BIT = 8;
    localparam int IMM_LSB  = 0;
    localparam int IMM_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // True for the ten op codes the ALU implements
    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA,
            OP_SLTU, OP_SLT, OP_XNOR, OP_AND, OP_OR: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small operand register file: two asynchronous read ports, one
// synchronous write port, all entries cleared by reset.
module alu_regfile #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_i,
    input  logic [$clog2(REG_CNT)-1:0] waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [$clog2(REG_CNT)-1:0] raddr1_i,
    output logic [DATA_W-1:0]          rdata1_o,
    input  logic [$clog2(REG_CNT)-1:0] raddr2_i,
    output logic [DATA_W-1:0]          rdata2_o
);

    logic [DATA_W-1:0] rf_q [REG_CNT];

    // Write port; every entry returns to zero on reset
    // NOTE: this array is small enough to carry a reset; large memories usually should not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = rf_q[raddr1_i];
    assign rdata2_o = rf_q[raddr2_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 8-bit combinational ALU: accepts one
// instruction, reads operands, drives the ALU for one cycle, writes the
// result back and returns it on a valid/ready response channel.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [INSTR_W-1:0]         in_instr_i,
    output logic [DATA_W-1:0]          alu_n1_o,
    output logic [DATA_W-1:0]          alu_n2_o,
    output logic [OP_W-1:0]            alu_op_o,
    input  logic [DATA_W-1:0]          alu_s1_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [$clog2(REG_CNT)-1:0] out_rd_o,
    output logic                       out_err_o,
    output logic [CNT_W-1:0]           ops_done_o
);

    localparam int RA_W = $clog2(REG_CNT);

    state_t            state_q, state_d;
    logic              ready_en_q;
    logic [DATA_W-1:0] alu_n1_q, alu_n1_d;
    logic [DATA_W-1:0] alu_n2_q, alu_n2_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [RA_W-1:0]   out_rd_q, out_rd_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  ops_done_q, ops_done_d;

    // Instruction field decode
    logic [OP_W-1:0]   f_op;
    logic [RA_W-1:0]   f_rd, f_rs1, f_rs2;
    logic              f_imm_sel;
    logic [IMM_W-1:0]  f_imm;
    logic              rsvd_unused;
    logic [DATA_W-1:0] rs1_data, rs2_data;

    assign f_op        = in_instr_i[OP_LSB +: OP_W];
    assign f_rd        = in_instr_i[RD_LSB +: RA_W];
    assign f_rs1       = in_instr_i[RS1_LSB +: RA_W];
    assign f_rs2       = in_instr_i[RS2_LSB +: RA_W];
    assign f_imm_sel   = in_instr_i[IMM_SEL];
    assign f_imm       = in_instr_i[IMM_LSB +: IMM_W];
    assign rsvd_unused = in_instr_i[RSVD_BIT];

    // Result is written back on the same edge it is captured for the response
    alu_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (state_q == EXEC),
        .waddr_i  (rd_q),
        .wdata_i  (alu_s1_i),
        .raddr1_i (f_rs1),
        .rdata1_o (rs1_data),
        .raddr2_i (f_rs2),
        .rdata2_o (rs2_data)
    );

    assign in_ready_o = ready_en_q && (state_q == IDLE);

    // Next-state and next-output logic for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case infers a latch.
        state_d     = state_q;
        alu_n1_d    = alu_n1_q;
        alu_n2_d    = alu_n2_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_err_d   = out_err_q;
        ops_done_d  = ops_done_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    alu_n1_d = rs1_data;
                    alu_n2_d = f_imm_sel ? DATA_W'(f_imm) : rs2_data;
                    rd_d     = f_rd;
                    if (op_is_legal(f_op)) begin
                        alu_op_d = f_op;
                        state_d  = EXEC;
                    end else begin
                        // Illegal op skips the ALU entirely and keeps the old op
                        out_data_d  = '0;
                        out_rd_d    = f_rd;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            EXEC: begin
                out_data_d  = alu_s1_i;
                out_rd_d    = rd_q;
                out_err_d   = 1'b0;
                out_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_en_q  <= 1'b0;
            alu_n1_q    <= '0;
            alu_n2_q    <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_err_q   <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            alu_n1_q    <= alu_n1_d;
            alu_n2_q    <= alu_n2_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_err_q   <= out_err_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign alu_n1_o    = alu_n1_q;
    assign alu_n2_o    = alu_n2_q;
    assign alu_op_o    = alu_op_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_rd_o    = out_rd_q;
    assign out_err_o   = out_err_q;
    assign ops_done_o  = ops_done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU closes the loop, directed
// instructions push hand-computed responses into a scoreboard queue and a
// negedge monitor pops and compares on every response handshake.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_instr;
    logic [7:0]  alu_n1, alu_n2, alu_s1;
    logic [3:0]  alu_op;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_rd;
    logic        out_err;
    logic [7:0]  ops_done;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] rd;
        logic       err;
    } resp_t;

    resp_t sb[$];
    resp_t mon_exp;
    int    n_checks = 0;
    int    n_fails  = 0;
    int    exp_done = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_instr_i  (in_instr),
        .alu_n1_o    (alu_n1),
        .alu_n2_o    (alu_n2),
        .alu_op_o    (alu_op),
        .alu_s1_i    (alu_s1),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_rd_o    (out_rd),
        .out_err_o   (out_err),
        .ops_done_o  (ops_done)
    );

    // Reference combinational ALU
    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b;
            4'b0101: r = a >> b;
            4'b1101: r = $unsigned($signed(a) >>> b);
            4'b0010: r = {7'b0, (a < b)};
            4'b0011: r = {7'b0, ($signed(a) < $signed(b))};
            4'b0100: r = ~(a ^ b);
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb alu_s1 = alu_model(alu_op, alu_n1, alu_n2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each handshaken response against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {31'b0, out_valid}, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("resp_data", {24'b0, out_data}, {24'b0, mon_exp.data});
                check("resp_rd",   {30'b0, out_rd},   {30'b0, mon_exp.rd});
                check("resp_err",  {31'b0, out_err},  {31'b0, mon_exp.err});
            end
        end
    end

    // Offer one instruction (called at a negedge); returns 1ns after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic isel, input logic [7:0] imm,
                         input logic [7:0] edata, input logic eerr, input bit push);
        int t = 0;
        if (push) begin
            sb.push_back('{data: edata, rd: rd, err: eerr});
            exp_done++;
        end
        in_instr = {op, rd, rs1, rs2, isel, 1'b1, imm};
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("issue_wait", {31'b0, (t < 50)}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until all expected responses have been handshaken, then settle one cycle
    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_wait", {31'b0, (t < 100)}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_ops_done",  {24'b0, ops_done},  32'd0);
        check("rst_alu_op",    {28'b0, alu_op},    32'd0);
        rst_n = 1'b1;
        #1 check("rel_in_ready_pre", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("rel_in_ready_post", {31'b0, in_ready}, 32'd1);

        // 1: r1 = r0 + 5, legal latency of one extra edge
        issue(4'b0000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 1'b0, 1);
        @(negedge clk) check("lat_legal_exec", {31'b0, out_valid}, 32'd0);
        @(negedge clk) check("lat_legal_resp", {31'b0, out_valid}, 32'd1);
        drain();
        check("t1_rf1", {24'b0, dut.u_rf.rf_q[1]}, 32'h05);
        check("t1_ops_done", {24'b0, ops_done}, exp_done);

        // 2: dependent back-to-back ops on r1 = 5
        issue(4'b1000, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00, 8'h00, 1'b0, 1);
        drain();
        issue(4'b0011, 2'd3, 2'd1, 2'd0, 1'b1, 8'hFB, 8'h00, 1'b0, 1);
        drain();
        issue(4'b0010, 2'd3, 2'd1, 2'd0, 1'b1, 8'hFB, 8'h01, 1'b0, 1);
        drain();
        check("t2_rf3", {24'b0, dut.u_rf.rf_q[3]}, 32'h01);

        // 3: shifts on r1 = 0x80, including an amount above 7
        issue(4'b0000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h80, 8'h80, 1'b0, 1);
        drain();
        issue(4'b1101, 2'd2, 2'd1, 2'd0, 1'b1, 8'h02, 8'hE0, 1'b0, 1);
        drain();
        issue(4'b0101, 2'd2, 2'd1, 2'd0, 1'b1, 8'h02, 8'h20, 1'b0, 1);
        drain();
        issue(4'b0001, 2'd2, 2'd1, 2'd0, 1'b1, 8'h09, 8'h00, 1'b0, 1);
        drain();

        // 4: illegal op responds on the accepting edge and leaves r1 alone
        issue(4'b1110, 2'd1, 2'd0, 2'd0, 1'b1, 8'h33, 8'h00, 1'b1, 1);
        @(negedge clk);
        check("lat_illegal", {31'b0, out_valid}, 32'd1);
        check("illegal_op_held", {28'b0, alu_op}, 32'h1);
        drain();
        check("t4_rf1", {24'b0, dut.u_rf.rf_q[1]}, 32'h80);
        check("t4_in_ready", {31'b0, in_ready}, 32'd1);
        check("t4_ops_done", {24'b0, ops_done}, exp_done);

        // 5: backpressure holds the response; a new instruction is ignored
        out_ready = 1'b0;
        issue(4'b0000, 2'd3, 2'd1, 2'd0, 1'b1, 8'h01, 8'h81, 1'b0, 1);
        @(negedge clk);
        in_instr = {4'b0000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h55};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid",    {31'b0, out_valid}, 32'd1);
            check("bp_data",     {24'b0, out_data},  32'h81);
            check("bp_in_ready", {31'b0, in_ready},  32'd0);
        end
        check("bp_ops_hold", {24'b0, ops_done}, exp_done - 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("bp_ops_done", {24'b0, ops_done}, exp_done);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) check("bp_no_extra", {31'b0, out_valid}, 32'd0);
        end
        check("bp_rf0", {24'b0, dut.u_rf.rf_q[0]}, 32'h00);

        // 6a: reset during EXEC aborts the instruction
        issue(4'b0000, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 8'h00, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", {31'b0, out_valid}, 32'd0);
        check("ar_out_data",  {24'b0, out_data},  32'd0);
        check("ar_ops_done",  {24'b0, ops_done},  32'd0);
        check("ar_alu_n1",    {24'b0, alu_n1},    32'd0);
        check("ar_in_ready",  {31'b0, in_ready},  32'd0);
        for (int i = 0; i < 4; i++) begin
            check("ar_rf", {24'b0, dut.u_rf.rf_q[i]}, 32'd0);
        end
        exp_done = 0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) check("ar_no_resp", {31'b0, out_valid}, 32'd0);
        end

        // 6b: 256 responses wrap the counter back to zero
        for (int i = 0; i < 256; i++) begin
            issue(4'b0111, 2'd3, 2'd0, 2'd0, 1'b1, 8'(i), 8'(i), 1'b0, 1);
            drain();
            if (i == 254) check("wrap_255", {24'b0, ops_done}, 32'd255);
        end
        check("wrap_0", {24'b0, ops_done}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
